// File: rtl/pe_flit_injector.sv
// PE-side flit injector: on start, walks the 1-cycle-latency dataout buffer and hands each word to the router local port.
// Optional feature macro INJ_SKIP_SELF_EN: words addressed to NODE_ID are dropped instead of injected.
module pe_flit_injector #(
  parameter int NODE_ID   = 0,
  parameter int FLIT_W    = 20,
  parameter int ADDR_W    = 5,
  parameter int NUM_WORDS = 30
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [FLIT_W-1:0] mem_rdata,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [ADDR_W:0]   sent_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [3:0]        SELF_DEST  = 4'(NODE_ID);
  localparam logic [FLIT_W-1:0] END_MARKER = {FLIT_W{1'b1}};
`ifdef INJ_SKIP_SELF_EN
  localparam logic SKIP_SELF = 1'b1;
`else
  localparam logic SKIP_SELF = 1'b0;
`endif

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   rd_ptr_r, rd_ptr_s;
  logic [ADDR_W:0]     sent_count_r, sent_count_s;
  logic [FLIT_W-1:0]   flit_out_r, flit_out_s;
  logic                flit_valid_r, flit_valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                skip_self_s;

  assign skip_self_s = SKIP_SELF && (mem_rdata[3:0] == SELF_DEST);

  // Next-state and next-register decode; every output except the buffer strobe is registered from here.
  always_comb begin
    state_s      = state_r;
    rd_ptr_s     = rd_ptr_r;
    sent_count_s = sent_count_r;
    flit_out_s   = flit_out_r;
    flit_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s      = FETCH;
          rd_ptr_s     = {ADDR_W{1'b0}};
          sent_count_s = {(ADDR_W + 1){1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        state_s = CAPTURE;
      end
      CAPTURE: begin
        flit_out_s = mem_rdata;
        if (mem_rdata == END_MARKER) begin
          state_s = DONE;
        end else if (skip_self_s) begin
          rd_ptr_s = rd_ptr_r + PTR_ONE;
          state_s  = (rd_ptr_r == LAST_PTR) ? DONE : FETCH;
        end else begin
          state_s      = SEND;
          flit_valid_s = 1'b1;
        end
      end
      SEND: begin
        // Hold the flit until the router takes it; valid drops the cycle after the handshake.
        if (flit_ready) begin
          sent_count_s = sent_count_r + CNT_ONE;
          rd_ptr_s     = rd_ptr_r + PTR_ONE;
          state_s      = (rd_ptr_r == LAST_PTR) ? DONE : FETCH;
        end else begin
          flit_valid_s = 1'b1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State and output registers with synchronous reset; a start seen together with RST is discarded.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r      <= IDLE;
      rd_ptr_r     <= {ADDR_W{1'b0}};
      sent_count_r <= {(ADDR_W + 1){1'b0}};
      flit_out_r   <= {FLIT_W{1'b0}};
      flit_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      rd_ptr_r     <= rd_ptr_s;
      sent_count_r <= sent_count_s;
      flit_out_r   <= flit_out_s;
      flit_valid_r <= flit_valid_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign mem_en     = (state_r == FETCH);
  assign mem_addr   = mem_en ? rd_ptr_r : {ADDR_W{1'b0}};
  assign flit_out   = flit_out_r;
  assign flit_valid = flit_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign sent_count = sent_count_r;

endmodule

// File: tb/tb_pe_flit_injector.sv
// Bench for pe_flit_injector: cycle table for the first run, directed corner cases,
// and randomized runs checked against a queue model of the buffer walk.
module tb_pe_flit_injector;
  localparam int NODE_ID   = 2;
  localparam int FLIT_W    = 20;
  localparam int ADDR_W    = 5;
  localparam int NUM_WORDS = 30;
  localparam logic [FLIT_W-1:0] MARKER = 20'hFFFFF;
`ifdef INJ_SKIP_SELF_EN
  localparam int T6_EXPECT = 28;
`else
  localparam int T6_EXPECT = 30;
`endif

  logic clk = 1'b0;
  logic RST, start, busy, done, mem_en, flit_valid, flit_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [FLIT_W-1:0] mem_rdata, flit_out;
  logic [ADDR_W:0]   sent_count;
  logic [FLIT_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [FLIT_W-1:0] exp_q [$];
  int vectors = 0;
  int miscompares = 0;

  pe_flit_injector #(.NODE_ID(NODE_ID), .FLIT_W(FLIT_W), .ADDR_W(ADDR_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .RST(RST), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  typedef struct {
    logic start, ready;
    logic busy, done, en;
    logic [ADDR_W-1:0] addr;
    logic valid;
    logic [FLIT_W-1:0] flit;
    logic [ADDR_W:0] cnt;
  } vec_t;
  vec_t tbl [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: words in address order up to the end marker or NUM_WORDS, minus self-addressed ones when skipping.
  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (mem[i] == MARKER) break;
`ifdef INJ_SKIP_SELF_EN
      if (mem[i][3:0] == 4'(NODE_ID)) continue;
`endif
      exp_q.push_back(mem[i]);
    end
  endtask

  task automatic fill_ramp(input logic [3:0] dest);
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = {16'(i + 1), dest};
  endtask

  // ready_mode 0: always ready, 1: random, 2: stall flit 0 for 7 cycles then always ready
  task automatic run(input int ready_mode, output int got, output int gap);
    int cycles, dones, last_hs, hold, exp_n;
    logic hs, stall_now, finished;
    logic [FLIT_W-1:0] pre_flit;
    cycles = 0; dones = 0; last_hs = -1; hold = 0; got = 0; gap = -1; finished = 1'b0;
    build_model();
    exp_n = exp_q.size();
    start = 1'b1; flit_ready = 1'b1;
    tick();
    start = 1'b0;
    while (!finished && cycles < 3000) begin
      case (ready_mode)
        0: flit_ready = 1'b1;
        1: flit_ready = ($urandom_range(0, 2) != 0);
        default: flit_ready = !(flit_valid && got == 0 && hold < 7);
      endcase
      hs = flit_valid && flit_ready;
      stall_now = flit_valid && !flit_ready;
      pre_flit = flit_out;
      if (stall_now) hold++;
      if (hs) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL extra_flit: got %0h expected no more flits", pre_flit);
        end else begin
          check("flit_out", pre_flit, exp_q.pop_front());
        end
        if (ready_mode == 0 && last_hs >= 0) check("hs_spacing", cycles - last_hs, 3);
        last_hs = cycles;
        got++;
      end
      tick();
      if (stall_now) begin
        check("stall_valid", flit_valid, 1'b1);
        check("stall_hold", flit_out, pre_flit);
        check("stall_mem_en", mem_en, 1'b0);
      end
      if (done) begin
        dones++;
        gap = cycles - last_hs;
        finished = 1'b1;
      end
      cycles++;
    end
    if (!finished) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: got no done in %0d cycles expected done", cycles);
    end
    tick();
    check("done_once", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("run_sent_count", sent_count, exp_n);
    check("run_flits", got, exp_n);
    check("run_dones", dones, 1);
  endtask

  initial begin
    int got, gap, n;
    RST = 1'b1; start = 1'b0; flit_ready = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 20'h0;
    mem[0] = 20'h00AA5;
    mem[1] = MARKER;
    tick(); tick();
    RST = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", flit_valid, 1'b0);
    check("rst_flit", flit_out, 20'h0);
    check("rst_sent", sent_count, 6'd0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_addr", mem_addr, 5'd0);

    // start, stall on flit 0 with a stray start, handshake, then the marker at word 1
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 20'h0,     6'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 20'h0,     6'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 20'h00AA5, 6'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 20'h00AA5, 6'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 20'h0,     6'd1};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 20'h0,     6'd1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 20'h0,     6'd1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 20'h0,     6'd1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 20'h0,     6'd1};
    for (int i = 0; i < 9; i++) begin
      start = tbl[i].start;
      flit_ready = tbl[i].ready;
      tick();
      check("tbl_busy", busy, tbl[i].busy);
      check("tbl_done", done, tbl[i].done);
      check("tbl_mem_en", mem_en, tbl[i].en);
      if (tbl[i].en) check("tbl_mem_addr", mem_addr, tbl[i].addr);
      check("tbl_valid", flit_valid, tbl[i].valid);
      if (tbl[i].valid) check("tbl_flit", flit_out, tbl[i].flit);
      check("tbl_sent", sent_count, tbl[i].cnt);
    end
    start = 1'b0;

    // full 30-word run, always ready
    fill_ramp(4'd5);
    run(0, got, gap);
    check("t1_sent", got, 30);
    check("t1_done_gap", gap, 0);

    // end marker at word 3
    mem[3] = MARKER;
    run(0, got, gap);
    check("t2_sent", got, 3);
    check("t2_done_gap", gap, 2);

    // backpressure on flit 0
    fill_ramp(4'd5);
    run(2, got, gap);
    check("t3_sent", got, 30);

    // reset while flit 4 is waiting in SEND, with start held high during reset
    start = 1'b1; flit_ready = 1'b1;
    tick();
    start = 1'b0; n = 0;
    for (int c = 0; c < 200 && !(flit_valid && n == 4); c++) begin
      flit_ready = 1'b1;
      if (flit_valid) n++;
      tick();
    end
    flit_ready = 1'b0;
    tick();
    check("t4_in_send", flit_valid, 1'b1);
    check("t4_pre_sent", sent_count, 6'd4);
    RST = 1'b1; start = 1'b1;
    tick();
    RST = 1'b0; start = 1'b0;
    check("t4_valid", flit_valid, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_sent", sent_count, 6'd0);
    check("t4_flit", flit_out, 20'h0);
    tick();
    check("t4_start_ignored", busy, 1'b0);
    check("t4_no_fetch", mem_en, 1'b0);
    run(0, got, gap);
    check("t4_replay", got, 30);

    // self-addressed words 1 and 4
    fill_ramp(4'd5);
    mem[1][3:0] = 4'(NODE_ID);
    mem[4][3:0] = 4'(NODE_ID);
    run(0, got, gap);
    check("t6_sent", got, T6_EXPECT);

    // random buffers, destinations, optional marker, random ready
    for (int r = 0; r < 8; r++) begin
      int pos;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
        mem[i] = {16'($urandom), 4'($urandom_range(0, 15))};
        if (mem[i] == MARKER) mem[i][4] = 1'b0;
      end
      pos = $urandom_range(0, 45);
      if (pos < NUM_WORDS) mem[pos] = MARKER;
      run(1, got, gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
